peri_timer_ctrl: RTL and testbench
==================================

# peri_timer_ctrl

Memory-mapped control front-end for the countdown timer peripheral. It sits between the processor data bus and the timer core. It turns bus writes into the timer's load pulse and start value, and it watches the returned count for expiry. It keeps a sticky expired flag, raises a maskable interrupt and can automatically re-arm the timer on expiry.

## Interface

Parameters:
- `AUTO_RELOAD_EN`, default 1: 1 builds the auto-reload path; 0 ties the CTRL.reload bit to 0 (reads 0, writes ignored).

Ports:
- `clk_i` input 1: system clock; all state changes on its rising edge.
- `rst_i` input 1: reset, asynchronous, active-low; asserted (0) forces every register to its reset value immediately.
- `we_i` input 1: bus write strobe, one cycle per write.
- `addr_i` input 4: byte address within the block; only bits [3:2] are decoded, bits [1:0] are ignored.
- `wdata_i` input 32: bus write data.
- `rdata_o` output 32: registered read data for the `addr_i` presented in the previous cycle.
- `cuenta_i` input 32: current count returned by the timer core.
- `data_o` output 32: start value driven to the timer core.
- `load_o` output 1: one-cycle load pulse to the timer core.
- `irq_o` output 1: level interrupt, equal to `expired & irq_en`.

## Operation

Register map (word offsets):
- 0x0 LOAD (R/W):
  - Write: store `wdata_i` into `data_o` and pulse `load_o`.
  - Read: return the stored value.
- 0x4 COUNT (R): return `cuenta_i`; writes are ignored.
- 0x8 CTRL (R/W):
  - bit0 `irq_en`.
  - bit1 `reload` (auto-reload enable).
  - Bits [31:2] read 0.
- 0xC STATUS:
  - bit0 `expired`: sticky; writing 1 clears it, writing 0 has no effect.
  - bit1 `running`: read-only, equal to `cuenta_i != 0`.
  - Other bits read 0.

Expiry detection:
- A register `prev_nz` captures `cuenta_i != 0` every cycle.
- Expiry event = `prev_nz & (cuenta_i == 0)`, i.e. a nonzero-to-zero transition only.
- A count that sits at 0 (after reset, or latched at 0) never re-triggers.
- The timer core always loads a nonzero value, so any load re-arms detection.

Expiry actions:
- The event sets `expired`.
- If `reload` = 1, the event also issues a `load_o` pulse in the next cycle with the current `data_o` value unchanged.

Simultaneous events:
- Software LOAD write in the same cycle as a pending auto-reload: exactly one `load_o` pulse is issued, carrying the new `wdata_i`.
- W1C of `expired` in the same cycle as an expiry event: set wins, and `expired` stays 1.
- CTRL write clearing `reload` in the same cycle as an expiry event: the new CTRL value governs, so no reload is issued.

## Timing

- Reset values: `data_o` = 0, `load_o` = 0, `irq_o` = 0, `rdata_o` = 0, CTRL = 0, `expired` = 0, `prev_nz` = 0.
- LOAD write at cycle N:
  - `data_o` and `load_o` = 1 are visible at cycle N+1.
  - `load_o` returns to 0 at cycle N+2 unless another load is issued.
- Expiry event at cycle N (`cuenta_i` first 0):
  - `expired` and `irq_o` (if enabled) are high at N+1.
  - The auto-reload `load_o` is high at N+1.
- `irq_o` follows `expired` and `irq_en` combinationally from registers; it has no extra latency.
- Read: `addr_i` sampled at cycle N gives `rdata_o` at N+1. Unmapped bits read 0.
- `rst_i` asserted mid-count: all outputs go to their reset values without waiting for a clock edge. The timer core is not reloaded, and an in-flight reload is dropped.

## Structure

- Shared package `peri_timer_pkg` holds:
  - Word-offset constants: `TMR_LOAD` = 2'd0, `TMR_COUNT` = 2'd1, `TMR_CTRL` = 2'd2, `TMR_STATUS` = 2'd3.
  - CTRL and STATUS bit-index constants.
  - A packed struct `tmr_ctrl_t` containing `{reload, irq_en}`.
- One sub-module is natural: `peri_timer_expiry`. Inputs: `cuenta_i`, `clk_i`, `rst_i`. Output: a one-cycle `expire` pulse.
- Address decode, registers, reload sequencing and the read mux live in the top module.

## Test plan

- Reset:
  - Stimulus: assert `rst_i` = 0 asynchronously between clock edges.
  - Response: all outputs read 0 immediately, and reads of CTRL and STATUS return 0 after release.
- Load path:
  - Stimulus: write 0x0000_0005 to 0x0.
  - Response: `data_o` = 5 and a single-cycle `load_o` one cycle later. A read of 0x0 returns 5, and a read of 0x4 returns the `cuenta_i` value driven by the bench.
- Expiry and W1C:
  - Stimulus: set CTRL = 0x1, then drive `cuenta_i` 3 → 2 → 1 → 0 and hold at 0.
  - Response: `expired` = 1 and `irq_o` = 1 one cycle after the 0, and no re-trigger while the count holds at 0. Writing 0x1 to 0xC clears both; writing 0x0 does not.
- Auto-reload:
  - Stimulus: set CTRL = 0x3 and LOAD = 0x10, then drive a nonzero-to-zero transition on `cuenta_i`.
  - Response: `load_o` pulses one cycle later with `data_o` = 0x10, and `expired` is set.
- Collisions:
  - Stimulus: apply a W1C on the same cycle as an expiry event, then a LOAD write of 0x20 on the same cycle as a pending reload.
  - Response: `expired` stays 1, and exactly one `load_o` pulse is issued with `data_o` = 0x20.
- Mid-operation reset:
  - Stimulus: assert `rst_i` while `cuenta_i` is nonzero and `reload` = 1.
  - Response: no `load_o` pulse follows, and a later transition to 0 does not set `expired`, because `prev_nz` was reset.

Source files
------------

// File: rtl/peri_timer_pkg.sv
// rtl/peri_timer_pkg.sv - shared register map, bit indices and CTRL layout for the timer front-end
package peri_timer_pkg;

    localparam logic [1:0] TMR_LOAD   = 2'd0;
    localparam logic [1:0] TMR_COUNT  = 2'd1;
    localparam logic [1:0] TMR_CTRL   = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

    localparam int CTRL_IRQ_EN_BIT  = 0;
    localparam int CTRL_RELOAD_BIT  = 1;
    localparam int STAT_EXPIRED_BIT = 0;
    localparam int STAT_RUNNING_BIT = 1;

    typedef struct packed {
        logic reload;
        logic irq_en;
    } tmr_ctrl_t;

endpackage

// File: rtl/peri_timer_expiry.sv
// rtl/peri_timer_expiry.sv - nonzero-to-zero detector on the returned timer count
module peri_timer_expiry (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] cuenta_i,
    output logic        expire
);

    logic prev_nz;
    logic cur_nz;

    assign cur_nz = |cuenta_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prev_nz <= 1'b0;
        end else begin
            prev_nz <= cur_nz;
        end
    end

    // A count parked at zero never re-fires; only the edge into zero does.
    assign expire = prev_nz & ~cur_nz;

endmodule

// File: rtl/peri_timer_ctrl.sv
// rtl/peri_timer_ctrl.sv - bus-mapped control, expiry flag, interrupt and auto-reload for the timer core
module peri_timer_ctrl
    import peri_timer_pkg::*;
#(
    parameter bit AUTO_RELOAD_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic [31:0] cuenta_i,
    output logic [31:0] data_o,
    output logic        load_o,
    output logic        irq_o
);

    logic [1:0]  sel;
    logic        wr_load;
    logic        wr_ctrl;
    logic        wr_status;
    logic        expire;
    logic        reload_fire;
    logic        expired;
    logic        expired_next;
    logic        running;
    logic        unused_addr;
    tmr_ctrl_t   ctrl;
    tmr_ctrl_t   ctrl_next;
    logic [31:0] rd_mux;

    assign sel         = addr_i[3:2];
    assign unused_addr = ^addr_i[1:0];
    assign wr_load     = we_i && (sel == TMR_LOAD);
    assign wr_ctrl     = we_i && (sel == TMR_CTRL);
    assign wr_status   = we_i && (sel == TMR_STATUS);
    assign running     = |cuenta_i;

    peri_timer_expiry u_expiry (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .cuenta_i (cuenta_i),
        .expire   (expire)
    );

    always_comb begin
        ctrl_next = ctrl;
        if (wr_ctrl) begin
            ctrl_next.irq_en = wdata_i[CTRL_IRQ_EN_BIT];
            ctrl_next.reload = wdata_i[CTRL_RELOAD_BIT] & AUTO_RELOAD_EN;
        end
    end

    // A same-cycle CTRL write decides whether this expiry reloads.
    assign reload_fire  = expire & ctrl_next.reload;
    assign expired_next = expire | (expired & ~(wr_status & wdata_i[STAT_EXPIRED_BIT]));

    always_comb begin
        rd_mux = 32'd0;
        case (sel)
            TMR_LOAD:   rd_mux = data_o;
            TMR_COUNT:  rd_mux = cuenta_i;
            TMR_CTRL:   rd_mux = {30'd0, ctrl};
            TMR_STATUS: begin
                rd_mux[STAT_EXPIRED_BIT] = expired;
                rd_mux[STAT_RUNNING_BIT] = running;
            end
            default:    rd_mux = 32'd0;
        endcase
    end

    // Software load and auto-reload merge into one pulse; data_o already holds the right value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o  <= 32'd0;
            load_o  <= 1'b0;
            ctrl    <= '0;
            expired <= 1'b0;
            rdata_o <= 32'd0;
        end else begin
            if (wr_load) begin
                data_o <= wdata_i;
            end
            load_o  <= wr_load | reload_fire;
            ctrl    <= ctrl_next;
            expired <= expired_next;
            rdata_o <= rd_mux;
        end
    end

    assign irq_o = expired & ctrl.irq_en;

endmodule

// File: tb/tb_peri_timer_ctrl.sv
// tb/tb_peri_timer_ctrl.sv - directed self-checking bench for peri_timer_ctrl
module tb_peri_timer_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        we_i;
    logic [3:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic [31:0] cuenta_i;
    logic [31:0] data_o;
    logic        load_o;
    logic        irq_o;

    int errors = 0;
    int checks = 0;

    peri_timer_ctrl #(.AUTO_RELOAD_EN(1'b1)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .cuenta_i (cuenta_i),
        .data_o   (data_o),
        .load_o   (load_o),
        .irq_o    (irq_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        tick();
        we_i    = 1'b0;
        wdata_i = 32'd0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        addr_i = a;
        tick();
        d = rdata_o;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        bus_write(4'h0, 32'h0000_0055);
        bus_read(4'h0, rd);
        checks++;
        if (data_o !== 32'h55) begin errors++; $display("FAIL reset_pre_data: got %h want %h", data_o, 32'h55); end
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (data_o !== 32'd0) begin errors++; $display("FAIL reset_async_data: got %h want 0", data_o); end
        checks++;
        if (load_o !== 1'b0 || irq_o !== 1'b0) begin errors++; $display("FAIL reset_async_pulse: got load=%b irq=%b want 0 0", load_o, irq_o); end
        checks++;
        if (rdata_o !== 32'd0) begin errors++; $display("FAIL reset_async_rdata: got %h want 0", rdata_o); end
        tick();
        rst_i = 1'b1;
        bus_read(4'h8, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_ctrl_read: got %h want 0", rd); end
        bus_read(4'hC, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_status_read: got %h want 0", rd); end
    endtask

    task automatic test_load();
        logic [31:0] rd;
        bus_write(4'h0, 32'h0000_0005);
        checks++;
        if (data_o !== 32'd5 || load_o !== 1'b1) begin errors++; $display("FAIL load_pulse: got data=%h load=%b want 5 1", data_o, load_o); end
        tick();
        checks++;
        if (load_o !== 1'b0) begin errors++; $display("FAIL load_single: got load=%b want 0", load_o); end
        cuenta_i = 32'h0000_1234;
        bus_read(4'h3, rd);
        checks++;
        if (rd !== 32'd5) begin errors++; $display("FAIL load_readback: got %h want 5", rd); end
        bus_read(4'h4, rd);
        checks++;
        if (rd !== 32'h1234) begin errors++; $display("FAIL count_read: got %h want 1234", rd); end
    endtask

    task automatic test_expiry();
        logic [31:0] rd;
        bus_write(4'h8, 32'h1);
        cuenta_i = 32'd3; tick();
        cuenta_i = 32'd2; tick();
        cuenta_i = 32'd1; tick();
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL expiry_early: got irq=%b want 0", irq_o); end
        cuenta_i = 32'd0; tick();
        checks++;
        if (irq_o !== 1'b1 || load_o !== 1'b0) begin errors++; $display("FAIL expiry_set: got irq=%b load=%b want 1 0", irq_o, load_o); end
        tick(); tick();
        bus_write(4'hC, 32'h1);
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL w1c_clear: got irq=%b want 0", irq_o); end
        tick(); tick(); tick();
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL hold_zero_retrigger: got irq=%b want 0", irq_o); end
        bus_read(4'hC, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL status_cleared: got %h want 0", rd); end
        cuenta_i = 32'd1; tick();
        cuenta_i = 32'd0; tick();
        bus_write(4'hC, 32'h0);
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL w0_no_clear: got irq=%b want 1", irq_o); end
        cuenta_i = 32'd9;
        bus_read(4'hC, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL status_running: got %h want 3", rd); end
        bus_write(4'hC, 32'h1);
    endtask

    task automatic test_reload();
        logic [31:0] rd;
        bus_write(4'h8, 32'h3);
        bus_write(4'h0, 32'h10);
        tick();
        bus_read(4'h8, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL ctrl_read: got %h want 3", rd); end
        cuenta_i = 32'h10; tick();
        cuenta_i = 32'd0;  tick();
        checks++;
        if (load_o !== 1'b1 || data_o !== 32'h10) begin errors++; $display("FAIL reload_pulse: got load=%b data=%h want 1 10", load_o, data_o); end
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL reload_expired: got irq=%b want 1", irq_o); end
        cuenta_i = 32'h10; tick();
        checks++;
        if (load_o !== 1'b0) begin errors++; $display("FAIL reload_single: got load=%b want 0", load_o); end
        bus_write(4'hC, 32'h1);
    endtask

    task automatic test_collisions();
        cuenta_i = 32'd0;
        we_i = 1'b1; addr_i = 4'hC; wdata_i = 32'h1;
        tick();
        we_i = 1'b0;
        checks++;
        if (irq_o !== 1'b1 || load_o !== 1'b1) begin errors++; $display("FAIL w1c_vs_set: got irq=%b load=%b want 1 1", irq_o, load_o); end
        cuenta_i = 32'h10; tick();
        cuenta_i = 32'd0;
        bus_write(4'h0, 32'h20);
        checks++;
        if (load_o !== 1'b1 || data_o !== 32'h20) begin errors++; $display("FAIL load_vs_reload: got load=%b data=%h want 1 20", load_o, data_o); end
        tick();
        checks++;
        if (load_o !== 1'b0) begin errors++; $display("FAIL load_vs_reload_once: got load=%b want 0", load_o); end
        cuenta_i = 32'h20; tick();
        cuenta_i = 32'd0;
        bus_write(4'h8, 32'h1);
        checks++;
        if (load_o !== 1'b0 || irq_o !== 1'b1) begin errors++; $display("FAIL ctrl_vs_reload: got load=%b irq=%b want 0 1", load_o, irq_o); end
        bus_write(4'hC, 32'h1);
    endtask

    task automatic test_midreset();
        logic [31:0] rd;
        bus_write(4'h8, 32'h3);
        cuenta_i = 32'd7; tick(); tick();
        cuenta_i = 32'd0;
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (load_o !== 1'b0 || irq_o !== 1'b0) begin errors++; $display("FAIL midreset_async: got load=%b irq=%b want 0 0", load_o, irq_o); end
        tick();
        checks++;
        if (load_o !== 1'b0) begin errors++; $display("FAIL midreset_no_reload: got load=%b want 0", load_o); end
        rst_i = 1'b1;
        bus_write(4'h8, 32'h3);
        tick();
        checks++;
        if (load_o !== 1'b0 || irq_o !== 1'b0) begin errors++; $display("FAIL midreset_no_expiry: got load=%b irq=%b want 0 0", load_o, irq_o); end
        bus_read(4'hC, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL midreset_status: got %h want 0", rd); end
    endtask

    initial begin
        rst_i    = 1'b0;
        we_i     = 1'b0;
        addr_i   = 4'h0;
        wdata_i  = 32'd0;
        cuenta_i = 32'd0;
        test_reset();
        test_load();
        test_expiry();
        test_reload();
        test_collisions();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
